digit_serial_subtractor: RTL and testbench
==========================================

// Module: digit_serial_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor with borrow: diff = in1 - in2 - bin, computed CHUNK bits per clock.
//  Serves as the inverse-direction companion to the 64-bit ripple-carry adder in the arithmetic datapath.
//  Area-lean alternative for the ALU; a one-shot start/done handshake launches each operation.
// PARAMETERS
//  WIDTH  64  operand/result width in bits
//  CHUNK  8   bits processed per RUN cycle; WIDTH % CHUNK must be 0 (elaboration error otherwise)
// PORTS
//  clk    in   1      rising-edge clock; the only clock in the block
//  rst_n  in   1      reset, asynchronous assert, active-low
//  start  in   1      request; sampled only when busy=0
//  in1    in   WIDTH  minuend (unsigned or two's complement)
//  in2    in   WIDTH  subtrahend
//  bin    in   1      borrow-in
//  busy   out  1      operation in progress; start ignored while high
//  done   out  1      one-cycle pulse: diff/bout/ovf valid
//  diff   out  WIDTH  result, held until next accepted start
//  bout   out  1      unsigned borrow-out: 1 iff in1 < in2 + bin
//  ovf    out  1      signed overflow of in1 - in2 - bin
// BEHAVIOUR
//  Interface: one clock; reset asynchronous, active-low; ports named clk and rst_n.
//  Reset (rst_n=0, any state, incl. mid-operation): state=IDLE; busy, done, diff, bout, ovf = 0; operand regs and chunk counter cleared.
//  NCH = WIDTH/CHUNK. States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at edge E0 latches in1, in2, bin (borrow reg = bin), cnt=0, busy=1 -> RUN. Inputs may change after E0.
//  RUN: each edge computes chunk cnt, LSB chunk first:
//   {c, d} = a_chunk + ~b_chunk + ~borrow; diff chunk = d; borrow = ~c; cnt++.
//  At edge E0+NCH (last chunk): diff complete, bout = final borrow, ovf = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]);
//   done=1, busy=0 -> DONE. Latency start->done = NCH cycles (8 for defaults).
//  DONE: done drops at the next edge. start=1 here is accepted as in IDLE (back-to-back, done and new busy coincide).
//  start while busy=1 is ignored, with no effect on the operation in flight.
//  Outputs diff/bout/ovf change only at the completing edge; they stay stable during RUN of the next op until it completes.
//  Unsigned wrap: result modulo 2^WIDTH; 0 - 0 - 1 -> all ones, bout=1.
// STRUCTURE
//  Shared header (`include): state encodings ST_IDLE/ST_RUN/ST_DONE, NCH derivation macro, CHUNK legality check.
//  Sub-module sub_chunk #(CHUNK): combinational a, b, bin -> d, bout slice; instantiated once and driven from the
//   operand shift registers (shift right by CHUNK each RUN cycle; result shifted in at MSB).
//  Counter width = $clog2(NCH)+1.
// TESTING (defaults WIDTH=64, CHUNK=8)
//  1 in1=68372643823854, in2=32458462378421, bin=0 -> done after 8 cycles, diff=35914181445433, bout=0, ovf=0.
//  2 same operands, bin=1 -> diff=35914181445432, bout=0.
//  3 in1=13, in2=18446744073709551602, bin=0 -> diff=27, bout=1; then bin=1 -> diff=26, bout=1.
//  4 in1=64'h8000_0000_0000_0000, in2=1, bin=0 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0; in1=0, in2=0, bin=1 -> all ones, bout=1, ovf=0.
//  5 start held high continuously, with operands changing each cycle -> ops accepted only at E0 and at each DONE cycle;
//    every result matches the operands latched at its accept edge; busy never pulses a second start mid-op.
//  6 rst_n low at RUN cycle 4, then start with test-1 operands -> all outputs 0 during reset; after release, one
//    clean result identical to test 1 exactly 8 cycles after start; no spurious done.

Source files
------------

// File: rtl/digit_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_subtractor_pkg
//  Description : Shared state encoding and parameter helpers for the
//                digit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_serial_subtractor_pkg;

    // Operation sequencing: IDLE -> RUN -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of chunks needed to cover the full operand width
    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A chunk size is legal only if it tiles the operand exactly
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_subtractor_sub_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : sub_chunk
//  Description : Combinational CHUNK-bit subtract slice with borrow in/out,
//                built as a + ~b + ~bin so the carry out is the inverted borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] w_sum;

    // Two's-complement subtract: carry out of the adder is NOT borrow
    always_comb begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
        d     = w_sum[CHUNK-1:0];
        bout  = ~w_sum[CHUNK];
    end

endmodule
`default_nettype wire

// File: rtl/digit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_subtractor
//  Description : Multi-cycle WIDTH-bit subtractor, diff = in1 - in2 - bin,
//                processing CHUNK bits per clock, LSB chunk first, with a
//                one-shot start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_subtractor
    import digit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int c_nch  = nch(WIDTH, CHUNK);
    localparam int c_cntw = $clog2(c_nch) + 1;

    // Reject chunk sizes that do not tile the operand
    generate
        if (!chunk_ok(WIDTH, CHUNK)) begin : g_chunk_illegal
            $error("digit_serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;        // minuend; result chunks shift in at the MSB
    logic [WIDTH-1:0]   r_b;        // subtrahend; shifts right, zero-filled
    logic               r_borrow;
    logic               r_a_msb;    // operand sign bits kept for overflow
    logic               r_b_msb;
    logic [c_cntw-1:0]  r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_a_next;
    logic               w_last;

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Next minuend register: drop the consumed chunk, insert the result chunk on top
    always_comb begin
        w_a_next = WIDTH'({w_d, r_a} >> CHUNK);
        w_last   = (r_cnt == c_cntw'(c_nch - 1));
    end

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= in1;
                        r_b      <= in2;
                        r_borrow <= bin;
                        r_a_msb  <= in1[WIDTH-1];
                        r_b_msb  <= in2[WIDTH-1];
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a      <= w_a_next;
                    r_b      <= r_b >> CHUNK;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff  <= w_a_next;
                        r_bout  <= w_bout;
                        r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d[CHUNK-1]);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_serial_subtractor
//  Description : Scoreboard bench for digit_serial_subtractor (64/8 defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_subtractor;

    localparam int W   = 64;
    localparam int CH  = 8;
    localparam int NCH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          bin;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff;
    logic          bout;
    logic          ovf;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t          q[$];
    int            n_checks  = 0;
    int            n_errors  = 0;
    int            cyc       = 0;
    int            n_acc     = 0;
    logic [W-1:0]  last_diff = '0;

    digit_serial_subtractor #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: wide unsigned for borrow, wide signed for overflow
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi, input int c);
        exp_t          m;
        logic [W:0]    u;
        logic [W+1:0]  s;
        u = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        s = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} - {{(W+1){1'b0}}, bi};
        m.diff    = u[W-1:0];
        m.bout    = u[W];
        m.ovf     = !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
        m.acc_cyc = c;
        return m;
    endfunction

    // Accept detection: push the expected result when an op is launched
    always @(posedge clk) begin
        cyc++;
        if (rst_n && start && !busy) begin
            q.push_back(model(in1, in2, bin, cyc));
            n_acc++;
        end
    end

    // An aborted operation never produces a result
    always @(negedge rst_n) begin
        q.delete();
        last_diff = '0;
    end

    // Result monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("diff", diff, e.diff);
                chk("bout", {63'd0, bout}, {63'd0, e.bout});
                chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                chk("latency", 64'(cyc - e.acc_cyc), 64'(NCH));
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                last_diff = e.diff;
            end
        end
    end

    // Launch one op from IDLE, scramble inputs afterwards, wait for completion
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int k;
        start = 1'b1; in1 = a; in2 = b; bin = bi;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; bin = 1'($urandom);
        chk("hold_diff", diff, last_diff);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_diff"}, diff, 64'd0);
        chk({tag, "_bout"}, {63'd0, bout}, 64'd0);
        chk({tag, "_ovf"},  {63'd0, ovf},  64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int k;
        rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1/2
        do_op(64'd68372643823854, 64'd32458462378421, 1'b0);
        chk("t1_diff", diff, 64'd35914181445433);
        chk("t1_bout", {63'd0, bout}, 64'd0);
        chk("t1_ovf",  {63'd0, ovf},  64'd0);
        do_op(64'd68372643823854, 64'd32458462378421, 1'b1);
        chk("t2_diff", diff, 64'd35914181445432);
        chk("t2_bout", {63'd0, bout}, 64'd0);

        // Test 3: unsigned wrap with borrow
        do_op(64'd13, 64'd18446744073709551602, 1'b0);
        chk("t3a_diff", diff, 64'd27);
        chk("t3a_bout", {63'd0, bout}, 64'd1);
        do_op(64'd13, 64'd18446744073709551602, 1'b1);
        chk("t3b_diff", diff, 64'd26);
        chk("t3b_bout", {63'd0, bout}, 64'd1);

        // Test 4: signed overflow and 0-0-1
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        chk("t4a_diff", diff, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t4a_ovf",  {63'd0, ovf},  64'd1);
        chk("t4a_bout", {63'd0, bout}, 64'd0);
        do_op(64'd0, 64'd0, 1'b1);
        chk("t4b_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4b_bout", {63'd0, bout}, 64'd1);
        chk("t4b_ovf",  {63'd0, ovf},  64'd0);

        // Test 5: start held high, operands changing every cycle
        acc0 = n_acc;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; bin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("t5_accepts", 64'(n_acc - acc0), 64'd4);
        k = 0;
        while ((q.size() != 0 || busy) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("t5_drain", 64'(q.size()), 64'd0);
        @(negedge clk);

        // Test 6: reset in the middle of an operation
        start = 1'b1; in1 = 64'd68372643823854; in2 = 64'd32458462378421; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        chk_outputs_zero("midrst_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_op(64'd68372643823854, 64'd32458462378421, 1'b0);
        chk("t6_diff", diff, 64'd35914181445433);
        chk("t6_bout", {63'd0, bout}, 64'd0);
        chk("t6_left", 64'(q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
